// File: rtl/lif_neuron_array_if.sv
// rtl/lif_neuron_array_if.sv - synaptic beat input and spike result stream bundle
interface lif_neuron_array_if #(
  parameter int CUR_W = 25,
  parameter int IDX_W = 5
);
  logic                    i_valid;
  logic signed [CUR_W-1:0] i_exc_current;
  logic signed [CUR_W-1:0] i_inh_current;
  logic                    o_ready;
  logic                    o_valid;
  logic                    o_spike;
  logic [IDX_W-1:0]        o_neuron_idx;

  modport master (
    output i_valid, i_exc_current, i_inh_current,
    input  o_ready, o_valid, o_spike, o_neuron_idx
  );

  modport slave (
    input  i_valid, i_exc_current, i_inh_current,
    output o_ready, o_valid, o_spike, o_neuron_idx
  );
endinterface

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - parametrised LIF neuron engine; adaptive threshold under ADAPTIVE_TH_EN
module lif_neuron_array #(
  parameter int                      N_NRN      = 18,
  parameter int                      CUR_W      = 25,
  parameter int                      V_W        = 32,
  parameter int                      CNT_W      = 7,
  parameter int                      LEAK_SHIFT = 4,
  parameter logic signed [V_W-1:0]   V_TH       = 32'sd4096,
  parameter logic signed [V_W-1:0]   V_RST      = 32'sd0,
  parameter int                      REFR       = 5,
  parameter logic signed [CUR_W-1:0] INH_W      = 25'sd512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_init,
  input  logic                       i_cnt_clr,
  input  logic                       i_s_lern,
  input  logic                       i_s_infr,
  lif_neuron_array_if.slave          bus,
  output logic [N_NRN-1:0]           o_spike_vec,
  output logic [N_NRN*CNT_W-1:0]     o_post_cnt,
  output logic signed [CUR_W-1:0]    o_inhbt,
  output logic                       o_inh_valid
);
  localparam int IDX_W = $clog2(N_NRN);
  localparam int RF_W  = (REFR < 1) ? 1 : $clog2(REFR + 1);
  localparam int TS_W  = $clog2(N_NRN + 1);
  localparam int E_W   = V_W + 2;
  localparam int P_W   = CUR_W + TS_W + 1;
  localparam logic [IDX_W-1:0]      LAST    = IDX_W'(N_NRN - 1);
  localparam logic [RF_W-1:0]       RF_INIT = RF_W'(REFR);
  localparam logic signed [E_W-1:0] V_MAX_E = E_W'({1'b0, {(V_W-1){1'b1}}});
  localparam logic signed [E_W-1:0] V_MIN_E = ~V_MAX_E;
  localparam logic signed [V_W-1:0] V_MAX   = {1'b0, {(V_W-1){1'b1}}};
  localparam logic signed [V_W-1:0] V_MIN   = ~V_MAX;
  localparam logic signed [P_W-1:0] C_MAX_P = P_W'({1'b0, {(CUR_W-1){1'b1}}});
  localparam logic signed [P_W-1:0] C_MIN_P = ~C_MAX_P;

  typedef enum logic {RUN, INIT} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]        init_cnt, beat_idx, s1_idx;
  logic                    s1_valid, accept, ts_end, spike, count_it;
  logic signed [CUR_W-1:0] s1_exc, s1_inh;
  logic signed [V_W-1:0]   v_mem [N_NRN];
  logic [RF_W-1:0]         refr_mem [N_NRN];
  logic [CNT_W-1:0]        cnt_mem [N_NRN];
  logic [N_NRN-1:0]        cur_vec, cur_vec_d;
  logic [TS_W-1:0]         ts_spikes, ts_spikes_d;
  logic signed [E_W-1:0]   v_e, leak_e, exc_e, inh_e, sum_e, th_e, vs_e;
  logic signed [V_W-1:0]   v_upd, v_new, v_cur;
  logic [RF_W-1:0]         refr_cur, refr_new;
  logic signed [P_W-1:0]   prod;
  logic signed [CUR_W-1:0] inh_sat;
`ifdef ADAPTIVE_TH_EN
  logic signed [V_W-1:0]   theta_mem [N_NRN];
  logic signed [V_W-1:0]   theta_cur, theta_new;
  logic signed [E_W-1:0]   theta_e;
`endif

  assign bus.o_ready = (state_q == RUN);
  assign accept      = bus.i_valid && bus.o_ready && !i_init;
  assign ts_end      = bus.o_valid && (bus.o_neuron_idx == LAST);
  assign count_it    = s1_valid && spike && (i_s_lern || i_s_infr);

  for (genvar k = 0; k < N_NRN; k++) begin : g_cnt
    assign o_post_cnt[k*CNT_W +: CNT_W] = cnt_mem[k];
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // next state: init request wins from anywhere, init sweep ends after the last neuron
  always_comb begin
    state_d = state_q;
    if (i_init) state_d = INIT;
    else if (state_q == INIT && init_cnt == LAST) state_d = RUN;
  end

  // membrane update for the neuron sitting in stage 1
  always_comb begin
    v_cur    = v_mem[s1_idx];
    refr_cur = refr_mem[s1_idx];
    v_e      = {{2{v_cur[V_W-1]}}, v_cur};
    leak_e   = v_e >>> LEAK_SHIFT;
    exc_e    = {{(E_W-CUR_W){s1_exc[CUR_W-1]}}, s1_exc};
    inh_e    = {{(E_W-CUR_W){s1_inh[CUR_W-1]}}, s1_inh};
    sum_e    = v_e - leak_e + exc_e - inh_e;
    if (sum_e > V_MAX_E)      v_upd = V_MAX;
    else if (sum_e < V_MIN_E) v_upd = V_MIN;
    else                      v_upd = sum_e[V_W-1:0];
    vs_e = {{2{v_upd[V_W-1]}}, v_upd};
`ifdef ADAPTIVE_TH_EN
    theta_cur = theta_mem[s1_idx];
    th_e      = {{2{V_TH[V_W-1]}}, V_TH} + {{2{theta_cur[V_W-1]}}, theta_cur};
    theta_e   = {{2{theta_cur[V_W-1]}}, theta_cur} + E_W'(1 << LEAK_SHIFT);
    theta_new = (theta_e > V_MAX_E) ? V_MAX : theta_e[V_W-1:0];
`else
    th_e = {{2{V_TH[V_W-1]}}, V_TH};
`endif
    spike    = 1'b0;
    v_new    = v_upd;
    refr_new = '0;
    if (refr_cur != '0) begin
      v_new    = V_RST;
      refr_new = refr_cur - RF_W'(1);
    end else if (vs_e >= th_e) begin
      spike    = 1'b1;
      v_new    = V_RST;
      refr_new = RF_INIT;
    end
  end

  // timestep accumulators restart when the last neuron's result is latched
  always_comb begin
    cur_vec_d   = ts_end ? '0 : cur_vec;
    ts_spikes_d = ts_end ? '0 : ts_spikes;
    if (s1_valid) begin
      cur_vec_d[s1_idx] = spike;
      ts_spikes_d       = ts_spikes_d + TS_W'(spike);
    end
    prod = $signed({{(P_W-TS_W){1'b0}}, ts_spikes})
         * $signed({{(P_W-CUR_W){INH_W[CUR_W-1]}}, INH_W});
    if (prod > C_MAX_P)      inh_sat = C_MAX_P[CUR_W-1:0];
    else if (prod < C_MIN_P) inh_sat = C_MIN_P[CUR_W-1:0];
    else                     inh_sat = prod[CUR_W-1:0];
  end

  // per-neuron state: init sweep, pipeline writeback and spike counters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_NRN; k++) begin
        v_mem[k]    <= V_RST;
        refr_mem[k] <= '0;
        cnt_mem[k]  <= '0;
      end
    end else begin
      if (i_cnt_clr) for (int k = 0; k < N_NRN; k++) cnt_mem[k] <= '0;
      if (state_q == INIT && !i_init) begin
        v_mem[init_cnt]    <= V_RST;
        refr_mem[init_cnt] <= '0;
        cnt_mem[init_cnt]  <= '0;
      end else if (s1_valid && !i_init) begin
        v_mem[s1_idx]    <= v_new;
        refr_mem[s1_idx] <= refr_new;
        if (count_it)
          cnt_mem[s1_idx] <= i_cnt_clr ? CNT_W'(1)
                           : (&cnt_mem[s1_idx]) ? cnt_mem[s1_idx]
                           : cnt_mem[s1_idx] + CNT_W'(1);
      end
    end
  end

`ifdef ADAPTIVE_TH_EN
  // adaptive threshold grows on learning spikes; only a hard reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_NRN; k++) theta_mem[k] <= '0;
    end else if (s1_valid && !i_init && spike && i_s_lern && !i_s_infr) begin
      theta_mem[s1_idx] <= theta_new;
    end
  end
`endif

  // beat index, two-stage pipeline and timestep outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt         <= '0;
      beat_idx         <= '0;
      s1_valid         <= 1'b0;
      s1_idx           <= '0;
      s1_exc           <= '0;
      s1_inh           <= '0;
      bus.o_valid      <= 1'b0;
      bus.o_spike      <= 1'b0;
      bus.o_neuron_idx <= '0;
      cur_vec          <= '0;
      ts_spikes        <= '0;
      o_spike_vec      <= '0;
      o_inhbt          <= '0;
      o_inh_valid      <= 1'b0;
    end else if (i_init) begin
      init_cnt    <= '0;
      beat_idx    <= '0;
      s1_valid    <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_spike <= 1'b0;
      cur_vec     <= '0;
      ts_spikes   <= '0;
      o_spike_vec <= '0;
      o_inh_valid <= 1'b0;
    end else begin
      if (state_q == INIT) init_cnt <= (init_cnt == LAST) ? '0 : init_cnt + IDX_W'(1);
      s1_valid <= accept;
      if (accept) begin
        s1_idx   <= beat_idx;
        s1_exc   <= bus.i_exc_current;
        s1_inh   <= bus.i_inh_current;
        beat_idx <= (beat_idx == LAST) ? '0 : beat_idx + IDX_W'(1);
      end
      bus.o_valid      <= s1_valid;
      bus.o_spike      <= s1_valid && spike;
      bus.o_neuron_idx <= s1_idx;
      cur_vec          <= cur_vec_d;
      ts_spikes        <= ts_spikes_d;
      o_inh_valid      <= ts_end;
      if (ts_end) begin
        o_spike_vec <= cur_vec;
        o_inhbt     <= inh_sat;
      end
    end
  end
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - directed table-driven bench for lif_neuron_array
module tb_lif_neuron_array;
  localparam int N  = 18;
  localparam int CW = 25;
  localparam int KW = 7;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset, i_init, i_cnt_clr, i_s_lern, i_s_infr;
  logic [N-1:0]           o_spike_vec;
  logic [N*KW-1:0]        o_post_cnt;
  logic signed [CW-1:0]   o_inhbt;
  logic                   o_inh_valid;

  lif_neuron_array_if #(.CUR_W(CW), .IDX_W(IW)) bus ();

  lif_neuron_array dut (
    .clk(clk), .reset(reset), .i_init(i_init), .i_cnt_clr(i_cnt_clr),
    .i_s_lern(i_s_lern), .i_s_infr(i_s_infr), .bus(bus),
    .o_spike_vec(o_spike_vec), .o_post_cnt(o_post_cnt),
    .o_inhbt(o_inhbt), .o_inh_valid(o_inh_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int na; int ea; int ia;
    int nb; int eb; int ib;
    bit lern;
    logic [N-1:0] vec;
    int inh;
    int cnt_a;
  } vec_t;

  vec_t tab [10];
  int   exc_tab [N];
  int   inh_tab [N];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_idx = 0;
  int   vcount = 0;
  int   rdy_low;
  logic [N-1:0] res_vec = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_stim(input int na, input int ea, input int ia,
                          input int nb, input int eb, input int ib);
    for (int k = 0; k < N; k++) begin
      exc_tab[k] = 0;
      inh_tab[k] = 0;
    end
    exc_tab[na] = ea; inh_tab[na] = ia;
    exc_tab[nb] = eb; inh_tab[nb] = ib;
  endtask

  task automatic drive_beats(input int first, input int last, input int clr_at);
    for (int k = first; k <= last; k++) begin
      @(posedge clk); #1;
      bus.i_valid       = 1'b1;
      bus.i_exc_current = CW'(exc_tab[k]);
      bus.i_inh_current = CW'(inh_tab[k]);
      i_cnt_clr         = (k == clr_at);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    i_cnt_clr   = 1'b0;
  endtask

  task automatic check_ts(input string name, input logic [N-1:0] ev, input int einh);
    int w;
    w = 0;
    idle();
    while (!o_inh_valid && w < 12) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_pulse"}, o_inh_valid, 1);
    chk({name, "_vec"}, o_spike_vec, ev);
    chk({name, "_ospike"}, res_vec, ev);
    chk({name, "_inhbt"}, o_inhbt, einh);
    @(negedge clk);
    chk({name, "_pulse_end"}, o_inh_valid, 0);
  endtask

  // result stream monitor: index order and per-neuron spike capture
  always @(negedge clk) begin
    if (!reset && bus.o_valid) begin
      chk("res_idx", bus.o_neuron_idx, exp_idx);
      res_vec[bus.o_neuron_idx] = bus.o_spike;
      exp_idx = (exp_idx == N - 1) ? 0 : exp_idx + 1;
      vcount++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        na  ea    ia    nb  eb    ib    lern vec       inh   cnt_a
    tab[0] = '{0, 0,    0,    1,  0,    0,    1,   18'h0,    0,    0};
    tab[1] = '{3, 5000, 0,    1,  0,    0,    1,   18'h8,    512,  1};
    tab[2] = '{3, 5000, 0,    5,  3000, 0,    1,   18'h0,    0,    1};
    tab[3] = '{3, 5000, 0,    5,  3000, 0,    1,   18'h20,   512,  1};
    tab[4] = '{3, 5000, 0,    9,  0,    4000, 1,   18'h0,    0,    1};
    tab[5] = '{3, 5000, 0,    9,  4000, 0,    1,   18'h0,    0,    1};
    tab[6] = '{3, 5000, 0,    9,  4000, 0,    1,   18'h200,  512,  1};
    tab[7] = '{3, 5000, 0,    7,  6000, 1000, 1,   18'h88,   1024, 2};
    tab[8] = '{0, 4095, 0,    1,  4096, 0,    1,   18'h2,    512,  0};
    tab[9] = '{2, 5000, 0,    0,  0,    0,    0,   18'h4,    512,  0};

    reset = 1'b1; i_init = 1'b0; i_cnt_clr = 1'b0; i_s_lern = 1'b1; i_s_infr = 1'b0;
    bus.i_valid = 1'b0; bus.i_exc_current = '0; bus.i_inh_current = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_vec", o_spike_vec, 0);
    chk("rst_cnt", o_post_cnt, 0);
    chk("rst_inhbt", o_inhbt, 0);
    chk("rst_inh_valid", o_inh_valid, 0);

    for (int t = 0; t < 10; t++) begin
      set_stim(tab[t].na, tab[t].ea, tab[t].ia, tab[t].nb, tab[t].eb, tab[t].ib);
      i_s_lern = tab[t].lern;
      drive_beats(0, N - 1, -1);
      check_ts($sformatf("ts%0d", t), tab[t].vec, tab[t].inh);
      chk($sformatf("ts%0d_cnt", t), o_post_cnt[tab[t].na*KW +: KW], tab[t].cnt_a);
    end

    i_s_lern = 1'b1;
    set_stim(0, 20000, 0, 1, 0, 0);
    for (int t = 0; t < 780; t++) drive_beats(0, N - 1, -1);
    check_ts("sat_last", 18'h0, 0);
    chk("sat_cnt0", o_post_cnt[0 +: KW], 127);
    chk("sat_cnt3", o_post_cnt[3*KW +: KW], 2);
    drive_beats(0, N - 1, 1);
    check_ts("clr", 18'h1, 512);
    chk("clr_cnt0", o_post_cnt[0 +: KW], 1);
    chk("clr_cnt3", o_post_cnt[3*KW +: KW], 0);
    chk("clr_cnt7", o_post_cnt[7*KW +: KW], 0);

    set_stim(4, 5000, 0, 1, 0, 0);
    drive_beats(0, N - 1, -1);
    check_ts("adp_spk", 18'h10, 512);
    set_stim(1, 0, 0, 2, 0, 0);
    for (int t = 0; t < 5; t++) begin
      drive_beats(0, N - 1, -1);
      check_ts($sformatf("adp_refr%0d", t), 18'h0, 0);
    end
    set_stim(4, 4100, 0, 1, 0, 0);
    drive_beats(0, N - 1, -1);
`ifdef ADAPTIVE_TH_EN
    check_ts("adp_th", 18'h0, 0);
`else
    check_ts("adp_th", 18'h10, 512);
`endif

    set_stim(2, 3000, 0, 1, 0, 0);
    vcount = 0;
    drive_beats(0, 7, -1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    i_init      = 1'b1;
    @(posedge clk); #1;
    i_init  = 1'b0;
    exp_idx = 0;
    rdy_low = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.o_ready) break;
      rdy_low++;
    end
    chk("init_ready_low", rdy_low, 18);
    chk("init_vcount", vcount, 7);
    chk("init_vec", o_spike_vec, 0);

    set_stim(2, 3000, 0, 1, 0, 0);
    @(posedge clk); #1;
    bus.i_valid       = 1'b1;
    bus.i_exc_current = CW'(exc_tab[0]);
    bus.i_inh_current = '0;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("lat_1cyc", bus.o_valid, 0);
    @(negedge clk);
    chk("lat_2cyc", bus.o_valid, 1);
    chk("lat_idx", bus.o_neuron_idx, 0);
    drive_beats(1, N - 1, -1);
    check_ts("post_init", 18'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
